ddr_arbiter: RTL and testbench



---
 rtl/rvga_types.sv | 21 ++
 rtl/ddr_arb_rr.sv | 22 ++
 rtl/ddr_arbiter.sv | 145 ++++++++++++++
 tb/tb_ddr_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvga_types.sv
// Shared RV-GA types: word and cacheline data types plus the DDR arbiter's
// FSM state and grant encodings.
package rvga_types;

  typedef logic [31:0]  rvga_word;
  typedef logic [255:0] rvga_cacheline;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE_I,
    DONE_D
  } arb_state_e;

  typedef enum logic {
    ICACHE,
    DCACHE
  } arb_grant_e;

endpackage

// File: rtl/ddr_arb_rr.sv
// Two-requester round-robin picker: on a tie the requester that was not
// granted last wins. Purely combinational.
module ddr_arb_rr
  import rvga_types::*;
(
  input  logic       req_icache,
  input  logic       req_dcache,
  input  arb_grant_e last_grant,
  output logic       grant_valid,
  output arb_grant_e grant
);

  always_comb begin
    grant_valid = req_icache | req_dcache;
    grant       = ICACHE;
    if (req_icache && req_dcache)
      grant = (last_grant == ICACHE) ? DCACHE : ICACHE;
    else if (req_dcache)
      grant = DCACHE;
  end

endmodule

// File: rtl/ddr_arbiter.sv
// Arbitrates the icache and dcache line requests onto one memory port, one
// transaction at a time. Define ARB_PERF_CNT_EN to add performance counters.
module ddr_arbiter
  import rvga_types::*;
#(
  parameter int addr_width = 32,
  parameter int line_width = 256,
  parameter int line_bytes = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] icache_iddr_addr,
  input  logic                  icache_iddr_read,
  output logic [line_width-1:0] iddr_icache_rdata,
  output logic                  iddr_icache_resp,
  input  logic [addr_width-1:0] dcache_dddr_addr,
  input  logic                  dcache_dddr_read,
  input  logic                  dcache_dddr_write,
  input  logic [line_width-1:0] dcache_dddr_wdata,
  output logic [line_width-1:0] dddr_dcache_rdata,
  output logic                  dddr_dcache_resp,
  output logic [addr_width-1:0] arb_mem_addr,
  output logic                  arb_mem_read,
  output logic                  arb_mem_write,
  output logic [line_width-1:0] arb_mem_wdata,
  input  logic [line_width-1:0] mem_arb_rdata,
  input  logic                  mem_arb_resp
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_icache_grants,
  output logic [31:0]           perf_dcache_grants,
  output logic [31:0]           perf_wait_cycles
`endif
);

  localparam logic [addr_width-1:0] align_mask = ~addr_width'(line_bytes - 1);

  arb_state_e state;
  arb_grant_e last_grant;
  arb_grant_e grant;
  logic       grant_valid;
  logic       icache_req;
  logic       dcache_req;

  assign icache_req = icache_iddr_read;
  assign dcache_req = dcache_dddr_read | dcache_dddr_write;

  ddr_arb_rr u_rr (
    .req_icache  (icache_req),
    .req_dcache  (dcache_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Grants are only taken in IDLE, so a request still high during DONE is never re-served.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      last_grant        <= DCACHE;
      arb_mem_addr      <= '0;
      arb_mem_read      <= 1'b0;
      arb_mem_write     <= 1'b0;
      arb_mem_wdata     <= '0;
      iddr_icache_rdata <= '0;
      iddr_icache_resp  <= 1'b0;
      dddr_dcache_rdata <= '0;
      dddr_dcache_resp  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last_grant <= grant;
            if (grant == ICACHE) begin
              arb_mem_addr  <= icache_iddr_addr & align_mask;
              arb_mem_read  <= 1'b1;
              arb_mem_write <= 1'b0;
              state         <= SERVE_I;
            end else begin
              // A dcache asserting both read and write is treated as a write.
              arb_mem_addr  <= dcache_dddr_addr & align_mask;
              arb_mem_read  <= ~dcache_dddr_write;
              arb_mem_write <= dcache_dddr_write;
              arb_mem_wdata <= dcache_dddr_wdata;
              state         <= SERVE_D;
            end
          end
        end
        SERVE_I: begin
          if (mem_arb_resp) begin
            iddr_icache_rdata <= mem_arb_rdata;
            arb_mem_read      <= 1'b0;
            arb_mem_write     <= 1'b0;
            iddr_icache_resp  <= 1'b1;
            state             <= DONE_I;
          end
        end
        SERVE_D: begin
          if (mem_arb_resp) begin
            if (arb_mem_read)
              dddr_dcache_rdata <= mem_arb_rdata;
            arb_mem_read     <= 1'b0;
            arb_mem_write    <= 1'b0;
            dddr_dcache_resp <= 1'b1;
            state            <= DONE_D;
          end
        end
        DONE_I: begin
          iddr_icache_resp <= 1'b0;
          state            <= IDLE;
        end
        DONE_D: begin
          dddr_dcache_resp <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic serving_i;
  logic serving_d;

  assign serving_i = (state == SERVE_I) || (state == DONE_I);
  assign serving_d = (state == SERVE_D) || (state == DONE_D);

  // Saturating counters; a wait cycle is one where a cache is blocked by the other's transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_icache_grants <= '0;
      perf_dcache_grants <= '0;
      perf_wait_cycles   <= '0;
    end else begin
      if ((state == IDLE) && grant_valid && (grant == ICACHE) && (perf_icache_grants != '1))
        perf_icache_grants <= perf_icache_grants + 32'd1;
      if ((state == IDLE) && grant_valid && (grant == DCACHE) && (perf_dcache_grants != '1))
        perf_dcache_grants <= perf_dcache_grants + 32'd1;
      if (((serving_i && dcache_req) || (serving_d && icache_req)) && (perf_wait_cycles != '1))
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_arbiter.sv
// Scoreboard bench for ddr_arbiter: directed cache requests, a latency-programmable
// memory model, and a monitor that checks every memory request and cache response.
module tb_ddr_arbiter;

  typedef struct {
    logic [31:0]  addr;
    logic         write;
    logic [255:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic         is_icache;
    logic [255:0] rdata;
  } resp_exp_t;

  logic         clk;
  logic         rst;
  logic [31:0]  icache_iddr_addr;
  logic         icache_iddr_read;
  logic [255:0] iddr_icache_rdata;
  logic         iddr_icache_resp;
  logic [31:0]  dcache_dddr_addr;
  logic         dcache_dddr_read;
  logic         dcache_dddr_write;
  logic [255:0] dcache_dddr_wdata;
  logic [255:0] dddr_dcache_rdata;
  logic         dddr_dcache_resp;
  logic [31:0]  arb_mem_addr;
  logic         arb_mem_read;
  logic         arb_mem_write;
  logic [255:0] arb_mem_wdata;
  logic [255:0] mem_arb_rdata;
  logic         mem_arb_resp;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]  perf_icache_grants;
  logic [31:0]  perf_dcache_grants;
  logic [31:0]  perf_wait_cycles;
`endif

  mem_exp_t     exp_mem[$];
  resp_exp_t    exp_resp[$];
  logic [255:0] mem_rd_q[$];
  int           mem_lat;
  bit           spurious_resp;
  int           n_compared;
  int           n_mismatched;

  localparam logic [255:0] line_a  = {32{8'hA5}};
  localparam logic [255:0] wdata_w = {8{32'h12345678}};
  localparam logic [255:0] line_b  = {16{16'hB00B}};
  localparam logic [255:0] line_c  = {16{16'hC0DE}};
  localparam logic [255:0] line_d  = {8{32'hD00D_0004}};
  localparam logic [255:0] wdata_5 = {8{32'hCAFE_0005}};
  localparam logic [255:0] line_e  = {8{32'hE1E1_0001}};
  localparam logic [255:0] line_f  = {8{32'hF00D_F00D}};
  localparam logic [255:0] junk    = {8{32'hDEADBEEF}};

  ddr_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .icache_iddr_addr  (icache_iddr_addr),
    .icache_iddr_read  (icache_iddr_read),
    .iddr_icache_rdata (iddr_icache_rdata),
    .iddr_icache_resp  (iddr_icache_resp),
    .dcache_dddr_addr  (dcache_dddr_addr),
    .dcache_dddr_read  (dcache_dddr_read),
    .dcache_dddr_write (dcache_dddr_write),
    .dcache_dddr_wdata (dcache_dddr_wdata),
    .dddr_dcache_rdata (dddr_dcache_rdata),
    .dddr_dcache_resp  (dddr_dcache_resp),
    .arb_mem_addr      (arb_mem_addr),
    .arb_mem_read      (arb_mem_read),
    .arb_mem_write     (arb_mem_write),
    .arb_mem_wdata     (arb_mem_wdata),
    .mem_arb_rdata     (mem_arb_rdata),
    .mem_arb_resp      (mem_arb_resp)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_icache_grants (perf_icache_grants),
    .perf_dcache_grants (perf_dcache_grants),
    .perf_wait_cycles   (perf_wait_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic pushMem(input logic [31:0] addr, input logic write, input logic [255:0] wdata);
    mem_exp_t m;
    m.addr  = addr;
    m.write = write;
    m.wdata = wdata;
    exp_mem.push_back(m);
  endtask

  task automatic pushResp(input logic is_icache, input logic [255:0] rdata);
    resp_exp_t r;
    r.is_icache = is_icache;
    r.rdata     = rdata;
    exp_resp.push_back(r);
  endtask

  // Acts as one cache: raise the request, hold it until resp, drop it the cycle after.
  task automatic applyStimulus(input bit is_icache, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [255:0] wdata,
                               output int cycles);
    bit seen;
    seen = 1'b0;
    @(posedge clk);
    #1;
    if (is_icache) begin
      icache_iddr_addr = addr;
      icache_iddr_read = rd;
    end else begin
      dcache_dddr_addr  = addr;
      dcache_dddr_read  = rd;
      dcache_dddr_write = wr;
      dcache_dddr_wdata = wdata;
    end
    cycles = 0;
    while (!seen && cycles < 100) begin
      @(negedge clk);
      cycles++;
      seen = is_icache ? (iddr_icache_resp === 1'b1) : (dddr_dcache_resp === 1'b1);
    end
    if (!seen) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL resp_timeout: got no resp after %0d cycles required a resp (icache=%0d addr=%h)",
               cycles, is_icache, addr);
    end
    @(posedge clk);
    #1;
    if (is_icache) begin
      icache_iddr_read = 1'b0;
    end else begin
      dcache_dddr_read  = 1'b0;
      dcache_dddr_write = 1'b0;
    end
  endtask

  // Memory model: checks each new request against the scoreboard, answers after mem_lat cycles.
  initial begin : mem_model
    mem_exp_t m;
    bit       busy;
    int       cnt;
    mem_arb_resp  = 1'b0;
    mem_arb_rdata = '0;
    busy = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      mem_arb_resp = 1'b0;
      if (spurious_resp) begin
        mem_arb_resp  = 1'b1;
        mem_arb_rdata = junk;
        spurious_resp = 1'b0;
      end else if (arb_mem_read === 1'b1 || arb_mem_write === 1'b1) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
          if (exp_mem.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL mem_unexpected: got request addr %h rd %0d wr %0d required no request",
                     arb_mem_addr, arb_mem_read, arb_mem_write);
          end else begin
            m = exp_mem.pop_front();
            checkOutput("mem_addr", 256'(arb_mem_addr), 256'(m.addr));
            checkOutput("mem_write", 256'(arb_mem_write), 256'(m.write));
            checkOutput("mem_read", 256'(arb_mem_read), 256'(!m.write));
            if (m.write)
              checkOutput("mem_wdata", arb_mem_wdata, m.wdata);
          end
        end
        cnt++;
        if (cnt >= mem_lat) begin
          mem_arb_resp = 1'b1;
          if (arb_mem_write === 1'b1)
            mem_arb_rdata = junk;
          else if (mem_rd_q.size() != 0)
            mem_arb_rdata = mem_rd_q.pop_front();
          else
            mem_arb_rdata = '0;
          busy = 1'b0;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  // Response monitor: every resp pulse must match the head of the scoreboard.
  initial begin : monitor
    resp_exp_t e;
    bit        prev_i;
    bit        prev_d;
    prev_i = 1'b0;
    prev_d = 1'b0;
    forever begin
      @(negedge clk);
      if (iddr_icache_resp === 1'b1 || dddr_dcache_resp === 1'b1) begin
        checkOutput("resp_exclusive", 256'(iddr_icache_resp & dddr_dcache_resp), 256'(0));
        checkOutput("resp_width", 256'((iddr_icache_resp & prev_i) | (dddr_dcache_resp & prev_d)), 256'(0));
        if (exp_resp.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL resp_unexpected: got icache_resp %0d dcache_resp %0d required none",
                   iddr_icache_resp, dddr_dcache_resp);
        end else begin
          e = exp_resp.pop_front();
          checkOutput("resp_port", 256'(iddr_icache_resp), 256'(e.is_icache));
          checkOutput("resp_rdata", e.is_icache ? iddr_icache_rdata : dddr_dcache_rdata, e.rdata);
        end
      end
      prev_i = (iddr_icache_resp === 1'b1);
      prev_d = (dddr_dcache_resp === 1'b1);
    end
  end

  initial begin : stimulus
    int c_i;
    int c_d;
    n_compared        = 0;
    n_mismatched      = 0;
    mem_lat           = 1;
    spurious_resp     = 1'b0;
    rst               = 1'b1;
    icache_iddr_addr  = '0;
    icache_iddr_read  = 1'b0;
    dcache_dddr_addr  = '0;
    dcache_dddr_read  = 1'b0;
    dcache_dddr_write = 1'b0;
    dcache_dddr_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_read", 256'(arb_mem_read), 256'(0));
    checkOutput("rst_mem_write", 256'(arb_mem_write), 256'(0));
    checkOutput("rst_mem_addr", 256'(arb_mem_addr), 256'(0));
    checkOutput("rst_mem_wdata", arb_mem_wdata, '0);
    checkOutput("rst_icache_resp", 256'(iddr_icache_resp), 256'(0));
    checkOutput("rst_dcache_resp", 256'(dddr_dcache_resp), 256'(0));
    checkOutput("rst_icache_rdata", iddr_icache_rdata, '0);
    checkOutput("rst_dcache_rdata", dddr_dcache_rdata, '0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] icache read, 2-cycle memory");
    mem_lat = 2;
    pushMem(32'h0000_1040, 1'b0, '0);
    mem_rd_q.push_back(line_a);
    pushResp(1'b1, line_a);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_1044, '0, c_i);
    checkOutput("lat_icache_read", 256'(c_i), 256'(4));

    $display("[TB] dcache write, 1-cycle memory");
    mem_lat = 1;
    pushMem(32'h0000_2000, 1'b1, wdata_w);
    pushResp(1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_2000, wdata_w, c_d);
    checkOutput("lat_dcache_write", 256'(c_d), 256'(3));
    checkOutput("icache_rdata_hold", iddr_icache_rdata, line_a);

    $display("[TB] simultaneous pair, 5-cycle memory");
    mem_lat = 5;
    pushMem(32'h0000_3000, 1'b0, '0);
    pushMem(32'h0000_4020, 1'b0, '0);
    mem_rd_q.push_back(line_b);
    mem_rd_q.push_back(line_c);
    pushResp(1'b1, line_b);
    pushResp(1'b0, line_c);
    fork
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_3000, '0, c_i);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_4020, '0, c_d);
    join
    checkOutput("lat_pair1_icache", 256'(c_i), 256'(7));
    checkOutput("lat_pair1_dcache", 256'(c_d), 256'(14));
`ifdef ARB_PERF_CNT_EN
    checkOutput("perf_icache_grants_a", 256'(perf_icache_grants), 256'(2));
    checkOutput("perf_dcache_grants_a", 256'(perf_dcache_grants), 256'(2));
    checkOutput("perf_wait_cycles_a", 256'(perf_wait_cycles), 256'(6));
`endif

    $display("[TB] second simultaneous pair, dcache read+write");
    mem_lat = 1;
    pushMem(32'h0000_5000, 1'b0, '0);
    pushMem(32'h0000_6000, 1'b1, wdata_5);
    mem_rd_q.push_back(line_d);
    pushResp(1'b1, line_d);
    pushResp(1'b0, line_c);
    fork
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_501F, '0, c_i);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_6008, wdata_5, c_d);
    join
    checkOutput("lat_pair2_icache", 256'(c_i), 256'(3));
    checkOutput("lat_pair2_dcache", 256'(c_d), 256'(6));

    $display("[TB] reset during dcache service");
    mem_lat = 100;
    pushMem(32'h0000_7000, 1'b0, '0);
    @(posedge clk);
    #1;
    dcache_dddr_addr = 32'h0000_7004;
    dcache_dddr_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("serve_d_read", 256'(arb_mem_read), 256'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dcache_dddr_read = 1'b0;
    @(negedge clk);
    checkOutput("abort_mem_read", 256'(arb_mem_read), 256'(0));
    checkOutput("abort_mem_write", 256'(arb_mem_write), 256'(0));
    checkOutput("abort_dcache_resp", 256'(dddr_dcache_resp), 256'(0));
    checkOutput("abort_dcache_rdata", dddr_dcache_rdata, '0);
`ifdef ARB_PERF_CNT_EN
    checkOutput("perf_clear", 256'(perf_icache_grants | perf_dcache_grants | perf_wait_cycles), 256'(0));
`endif
    mem_lat = 1;
    spurious_resp = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("spurious_mem_read", 256'(arb_mem_read), 256'(0));

    $display("[TB] back-to-back icache reads, 1-cycle memory");
    pushMem(32'h0000_8000, 1'b0, '0);
    pushMem(32'h0000_8040, 1'b0, '0);
    mem_rd_q.push_back(line_e);
    mem_rd_q.push_back(line_f);
    pushResp(1'b1, line_e);
    pushResp(1'b1, line_f);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_8000, '0, c_i);
    checkOutput("lat_b2b_first", 256'(c_i), 256'(3));
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_8044, '0, c_i);
    checkOutput("lat_b2b_second", 256'(c_i), 256'(3));
`ifdef ARB_PERF_CNT_EN
    checkOutput("perf_icache_grants_b", 256'(perf_icache_grants), 256'(2));
    checkOutput("perf_dcache_grants_b", 256'(perf_dcache_grants), 256'(0));
    checkOutput("perf_wait_cycles_b", 256'(perf_wait_cycles), 256'(0));
`endif

    repeat (5) @(negedge clk);
    checkOutput("resp_queue_drained", 256'(exp_resp.size()), 256'(0));
    checkOutput("mem_queue_drained", 256'(exp_mem.size()), 256'(0));
    checkOutput("dcache_rdata_final", dddr_dcache_rdata, '0);
    checkOutput("icache_rdata_final", iddr_icache_rdata, line_f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
